// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial two's-complement adder/subtractor, DIGIT bits per clock
// Start/busy/done handshake; s, cout and ovf are updated only when an operation completes.
module serial_addsub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
         $error("serial_addsub: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic [WIDTH-1:0]       opa;
   logic [WIDTH-1:0]       opb;
   logic [WIDTH-1:0]       acc;
   logic                   carry;
   logic [CW-1:0]          count;

   logic [DIGIT:0]         dsum;
   logic [WIDTH+DIGIT-1:0] acc_cat;
   logic [WIDTH-1:0]       acc_shift;
   logic                   last;
   logic                   accept;
   logic                   c_msb;

   // The result register fills from the top, so after N digits the first
   // digit has been pushed down to bit 0.
   always_comb begin
      dsum      = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      acc_cat   = {dsum[DIGIT-1:0], acc};
      acc_shift = acc_cat[WIDTH+DIGIT-1:DIGIT];
      last      = (count == LAST);
      accept    = start && ((state == IDLE) || (state == DONE));
      // On the last digit its top bit is the word MSB; recover the carry into it.
      c_msb     = dsum[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = start ? RUN : IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opa   <= '0;
         opb   <= '0;
         acc   <= '0;
         carry <= 1'b0;
         count <= '0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         opa   <= a;
         opb   <= b ^ {WIDTH{sub}};
         acc   <= '0;
         carry <= sub;
         count <= '0;
      end else if (state == RUN) begin
         opa   <= opa >> DIGIT;
         opb   <= opb >> DIGIT;
         acc   <= acc_shift;
         carry <= dsum[DIGIT];
         count <= count + 1'b1;
         if (last) begin
            s    <= acc_shift;
            cout <= dsum[DIGIT];
            ovf  <= c_msb ^ dsum[DIGIT];
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub at DIGIT = 4, 1 and 16
module tb_serial_addsub;

   localparam int NS [3] = '{4, 16, 1};

   logic        clk = 1'b0;
   logic        rst;
   logic        sub;
   logic [15:0] a;
   logic [15:0] b;
   logic [2:0]  start_v;
   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   logic [2:0]  cout_v;
   logic [2:0]  ovf_v;
   logic [15:0] s_v [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d4 (
      .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .a(a), .b(b),
      .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0])
   );
   serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .a(a), .b(b),
      .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
   );
   serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
      .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .a(a), .b(b),
      .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: unsigned compare gives NOT-borrow, signed range gives overflow.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic sb);
      logic [15:0] rs;
      logic        rc;
      logic        rv;
      int          r;
      if (sb) begin
         rs = x - y;
         rc = (x >= y);
         r  = int'($signed(x)) - int'($signed(y));
      end else begin
         rs = x + y;
         rc = ((int'(x) + int'(y)) > 65535);
         r  = int'($signed(x)) + int'($signed(y));
      end
      rv = (r > 32767) || (r < -32768);
      return {rv, rc, rs};
   endfunction

   task automatic check_result(input int d, input logic [17:0] exp, input string tag);
      check($sformatf("%s d%0d s", tag, d), 32'(s_v[d]), 32'(exp[15:0]));
      check($sformatf("%s d%0d cout", tag, d), 32'(cout_v[d]), 32'(exp[16]));
      check($sformatf("%s d%0d ovf", tag, d), 32'(ovf_v[d]), 32'(exp[17]));
   endtask

   task automatic wait_done(input int d, input int n_exp, input string tag);
      int j = 0;
      while (!done_v[d] && j < 64) begin
         @(negedge clk);
         j++;
      end
      check($sformatf("%s d%0d latency", tag, d), 32'(j), 32'(n_exp));
   endtask

   task automatic run_op(input logic [2:0] mask, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tsub, input string tag);
      logic [17:0] exp;
      logic [2:0]  got;
      exp = model(ta, tb_, tsub);
      a       = ta;
      b       = tb_;
      sub     = tsub;
      start_v = mask;
      @(posedge clk);
      @(negedge clk);
      start_v = 3'b000;
      a       = 16'($urandom);
      b       = 16'($urandom);
      sub     = 1'($urandom);
      got     = 3'b000;
      for (int d = 0; d < 3; d++) begin
         if (mask[d]) check($sformatf("%s d%0d busy", tag, d), 32'(busy_v[d]), 32'd1);
      end
      for (int j = 0; j < 64; j++) begin
         if (j > 0) @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (mask[d] && !got[d] && done_v[d]) begin
               check($sformatf("%s d%0d latency", tag, d), 32'(j), 32'(NS[d]));
               check_result(d, exp, tag);
               got[d] = 1'b1;
            end
         end
         if (got == mask) break;
      end
      for (int d = 0; d < 3; d++) begin
         if (mask[d] && !got[d]) check($sformatf("%s d%0d timeout", tag, d), 32'd0, 32'd1);
      end
      @(negedge clk);
      check($sformatf("%s done pulse width", tag), 32'(done_v & mask), 32'd0);
      for (int d = 0; d < 3; d++) begin
         if (mask[d]) check($sformatf("%s d%0d s held", tag, d), 32'(s_v[d]), 32'(exp[15:0]));
      end
   endtask

   initial begin
      int quiet;
      rst     = 1'b1;
      start_v = 3'b000;
      sub     = 1'b0;
      a       = '0;
      b       = '0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset d%0d busy", d), 32'(busy_v[d]), 32'd0);
         check($sformatf("reset d%0d done", d), 32'(done_v[d]), 32'd0);
         check_result(d, 18'd0, "reset");
      end
      rst = 1'b0;
      @(negedge clk);

      run_op(3'b111, 16'h1234, 16'h0FFF, 1'b0, "add_basic");
      run_op(3'b111, 16'h7FFF, 16'h0001, 1'b0, "add_ovf");
      run_op(3'b111, 16'hFFFF, 16'h0001, 1'b0, "add_carry");
      run_op(3'b111, 16'h0005, 16'h0007, 1'b0 ^ 1'b1, "sub_neg");
      run_op(3'b111, 16'h8000, 16'h0001, 1'b1, "sub_ovf");
      run_op(3'b111, 16'hA5C3, 16'h0000, 1'b1, "sub_zero");

      // Start pulsed during RUN must be ignored; a start in the DONE cycle chains.
      a = 16'h1234; b = 16'h0FFF; sub = 1'b0; start_v = 3'b001;
      @(posedge clk);
      @(negedge clk);
      start_v = 3'b000;
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start_v = 3'b001;
      @(posedge clk);
      @(negedge clk);
      start_v = 3'b000;
      wait_done(0, 2, "ignore_busy");
      check_result(0, model(16'h1234, 16'h0FFF, 1'b0), "ignore_busy");
      a = 16'h7FFF; b = 16'h0001; sub = 1'b0; start_v = 3'b001;
      @(posedge clk);
      @(negedge clk);
      start_v = 3'b000;
      check("chain busy", 32'(busy_v[0]), 32'd1);
      check("chain done low", 32'(done_v[0]), 32'd0);
      check("chain s undisturbed", 32'(s_v[0]), 32'h2233);
      wait_done(0, 4, "chain");
      check_result(0, model(16'h7FFF, 16'h0001, 1'b0), "chain");

      // Reset in the second RUN cycle aborts without a done pulse.
      @(negedge clk);
      a = 16'h4321; b = 16'h1111; sub = 1'b0; start_v = 3'b001;
      @(posedge clk);
      @(negedge clk);
      start_v = 3'b000;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort busy", 32'(busy_v[0]), 32'd0);
      check("abort done", 32'(done_v[0]), 32'd0);
      check_result(0, 18'd0, "abort");
      quiet = 0;
      repeat (8) begin
         @(negedge clk);
         if (done_v != 3'b000) quiet++;
      end
      check("abort no done pulse", 32'(quiet), 32'd0);
      run_op(3'b111, 16'h4321, 16'h1111, 1'b1, "after_abort");

      for (int i = 0; i < 24; i++) begin
         run_op(3'b111, 16'($urandom), 16'($urandom), 1'($urandom), $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
